if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage driving the IF/ID pipeline register.
- Holds the PC and issues held-until-ack requests to instruction memory.
- Presents {instr, pc, valid} to IF/ID with stall back-pressure and branch redirect/flush.
- One-entry skid buffer absorbs a memory response that arrives while IF/ID is stalled.

Parameters:
- PC_WIDTH, 64, PC and address width.
- INSTR_WIDTH, 32, instruction width.
- RESET_PC, 64'h0, first fetch address after reset.
- PC_INC, 4, byte increment per sequential fetch.

Ports:
- clock_In  input  1  sole clock; all state updates on posedge.
- reset_In  input  1  synchronous, active-high reset.
- stall_In  input  1  IF/ID not accepting this cycle.
- branch_taken_In  input  1  redirect/flush request.
- branch_target_In  input  PC_WIDTH  redirect address.
- imem_req_Out  output  1  memory request valid.
- imem_addr_Out  output  PC_WIDTH  request address; stable while imem_req_Out=1.
- imem_ack_In  input  1  response valid; may coincide with the request cycle.
- imem_rdata_In  input  INSTR_WIDTH  instruction, valid with imem_ack_In.
- instr_Out  output  INSTR_WIDTH  fetched instruction to IF/ID.
- pcOut_Out  output  PC_WIDTH  address of instr_Out (not PC+4).
- valid_Out  output  1  instr_Out/pcOut_Out meaningful.

Behaviour:
- Reset (synchronous, sampled at posedge when reset_In=1):
  - State IDLE; pc_q=RESET_PC; squash_q=0; skid empty.
  - valid_Out=0, instr_Out=0, pcOut_Out=0, imem_req_Out=0, imem_addr_Out=0.
  - Reset mid-request abandons the request; memory shares this reset.
- Handshake definitions:
  - Output accepted when valid_Out && !stall_In.
  - slot_free = !valid_Out || !stall_In.
- FSM:
  - IDLE -> REQ after 1 cycle.
  - REQ: imem_req_Out=1, imem_addr_Out=req_addr_q. Held unchanged until ack, regardless of stall.
  - REQ + ack, data kept, slot_free=1: data goes to output regs, pc_q += PC_INC, next request at new pc_q. Stay REQ. Single-cycle memory gives 1 instr/cycle.
  - REQ + ack, data kept, slot_free=0: data goes to skid, pc_q += PC_INC, go to WAIT_SPACE.
  - WAIT_SPACE: imem_req_Out=0. On output acceptance, skid moves to output (valid stays 1), skid cleared, go to REQ with addr=pc_q.
- Redirect (branch_taken_In=1) has priority over stall and ack:
  - pc_q=branch_target_In; valid_Out=0; skid cleared.
  - If in REQ without ack this cycle: squash_q=1, request stays held at old address. The squashed ack is discarded, squash_q is cleared, then REQ issues at the target.
  - If ack coincides with redirect: data discarded, next cycle REQ at target.
  - From WAIT_SPACE or IDLE: next cycle REQ at target.
  - Redirect while squash_q=1: only pc_q is updated.
- Stall: output regs and skid hold; no new request is issued while skid is full.
- Arithmetic: PC addition is modulo 2^PC_WIDTH; all-ones-minus-3 wraps to 0. No alignment checking.
- Simultaneous acceptance and ack in REQ: slot_free=1, so output is overwritten with new data; no loss.

Decomposition:
- Package if_pkg holds:
  - state enum {IDLE, REQ, WAIT_SPACE}
  - PC_INC, RESET_PC defaults
  - fetch_pkt struct {instr, pc}
- Sub-module if_skid_buffer: one entry, load/unload/clear, carries fetch_pkt plus a full flag.
- Top-level keeps the FSM, pc_q, req_addr_q and squash_q.

Test Plan:
- Reset, then single-cycle ack with mem[a]=a^32'hA5A5_0000, no stall -> first req at addr 0 the cycle after IDLE. Outputs (0,0xA5A50000), (4,0xA5A50004), ... on consecutive cycles.
- stall_In=1 for 3 cycles with valid_Out=1 and ack pending -> skid captures pc 8; req low during the stall. On release, pc 4, then 8, emerge in order; next req addr 12.
- 2-cycle-latency ack, branch_taken_In to 0x100 in first wait cycle -> addr stays 8 until ack, that data dropped. Next req at 0x100; valid_Out never shows pc 8.
- Redirect coincident with ack and stall=1, skid full -> valid_Out=0 next cycle, skid empty, req at target next cycle.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second fetch address 0.
- reset_In asserted while req outstanding -> next cycle all outputs zero, then req at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Holds the FSM state encoding and the fetch packet layout.
package if_pkg;

  localparam int PC_W = 64;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = '0;
  localparam int PC_INC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_SPACE
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_pkt;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry skid buffer holding a fetch packet.
// Priority: clear over load over unload.
module if_skid_buffer
  import if_pkg::*;
#(
  parameter type pkt_t = fetch_pkt
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic unload,
  input  logic clear,
  input  pkt_t din,
  output pkt_t dout,
  output logic full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, held-until-ack memory requests,
// IF/ID output registers with stall, redirect and a skid entry.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int PC_WIDTH = PC_W,
  parameter int INSTR_WIDTH = INSTR_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEF),
  parameter int PC_INC = PC_INC_DEF
) (
  input  logic                   clock_In,
  input  logic                   reset_In,
  input  logic                   stall_In,
  input  logic                   branch_taken_In,
  input  logic [PC_WIDTH-1:0]    branch_target_In,
  output logic                   imem_req_Out,
  output logic [PC_WIDTH-1:0]    imem_addr_Out,
  input  logic                   imem_ack_In,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_In,
  output logic [INSTR_WIDTH-1:0] instr_Out,
  output logic [PC_WIDTH-1:0]    pcOut_Out,
  output logic                   valid_Out
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } pkt_t;

  state_t state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] req_addr_q;
  logic [PC_WIDTH-1:0] pc_inc;
  logic squash_q;
  logic req_q;
  logic valid_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0] pc_out_q;

  logic accept;
  logic slot_free;
  logic skid_load;
  logic skid_unload;
  logic skid_full;
  pkt_t skid_in;
  pkt_t skid_out;

  assign accept = valid_q && !stall_In;
  assign slot_free = !valid_q || !stall_In;
  assign pc_inc = pc_q + PC_WIDTH'(PC_INC);

  assign skid_load = (state_q == REQ) && !branch_taken_In
    && imem_ack_In && !squash_q && !slot_free;
  assign skid_unload = (state_q == WAIT_SPACE)
    && !branch_taken_In && accept;
  assign skid_in = '{instr: imem_rdata_In, pc: req_addr_q};

  if_skid_buffer #(
    .pkt_t(pkt_t)
  ) u_skid (
    .clk   (clock_In),
    .rst   (reset_In),
    .load  (skid_load),
    .unload(skid_unload),
    .clear (branch_taken_In),
    .din   (skid_in),
    .dout  (skid_out),
    .full  (skid_full)
  );

  always_ff @(posedge clock_In) begin
    if (reset_In) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      squash_q   <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_out_q   <= '0;
    end else begin
      if (accept) valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
          if (branch_taken_In) begin
            pc_q       <= branch_target_In;
            req_addr_q <= branch_target_In;
            valid_q    <= 1'b0;
          end else begin
            req_addr_q <= pc_q;
          end
        end
        REQ: begin
          if (branch_taken_In) begin
            pc_q    <= branch_target_In;
            valid_q <= 1'b0;
            // the in-flight request must complete before retargeting
            if (imem_ack_In) begin
              squash_q   <= 1'b0;
              req_addr_q <= branch_target_In;
            end else begin
              squash_q <= 1'b1;
            end
          end else if (imem_ack_In) begin
            if (squash_q) begin
              squash_q   <= 1'b0;
              req_addr_q <= pc_q;
            end else if (slot_free) begin
              valid_q    <= 1'b1;
              instr_q    <= imem_rdata_In;
              pc_out_q   <= req_addr_q;
              pc_q       <= pc_inc;
              req_addr_q <= pc_inc;
            end else begin
              pc_q    <= pc_inc;
              state_q <= WAIT_SPACE;
              req_q   <= 1'b0;
            end
          end
        end
        WAIT_SPACE: begin
          if (branch_taken_In) begin
            pc_q       <= branch_target_In;
            req_addr_q <= branch_target_In;
            valid_q    <= 1'b0;
            state_q    <= REQ;
            req_q      <= 1'b1;
          end else if (accept && skid_full) begin
            valid_q    <= 1'b1;
            instr_q    <= skid_out.instr;
            pc_out_q   <= skid_out.pc;
            req_addr_q <= pc_q;
            state_q    <= REQ;
            req_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_Out = req_q;
  assign imem_addr_Out = req_addr_q;
  assign instr_Out = instr_q;
  assign pcOut_Out = pc_out_q;
  assign valid_Out = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-configurable
// memory model; a second instance checks PC wrap-around.
module tb_if_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic stall;
  logic br;
  logic [63:0] tgt;
  logic req;
  logic ack;
  logic [63:0] addr;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [63:0] pco;
  logic valid;
  int lat;
  int cnt;

  logic stall2;
  logic br2;
  logic [63:0] tgt2;
  logic req2;
  logic ack2;
  logic [63:0] addr2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [63:0] pco2;
  logic valid2;

  int checks = 0;
  int errors = 0;

  assign ack = req && (cnt == lat);
  assign rdata = addr[31:0] ^ 32'hA5A5_0000;
  assign ack2 = req2;
  assign rdata2 = addr2[31:0] ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else if (req && !ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  if_fetch_unit dut (
    .clock_In        (clk),
    .reset_In        (rst),
    .stall_In        (stall),
    .branch_taken_In (br),
    .branch_target_In(tgt),
    .imem_req_Out    (req),
    .imem_addr_Out   (addr),
    .imem_ack_In     (ack),
    .imem_rdata_In   (rdata),
    .instr_Out       (instr),
    .pcOut_Out       (pco),
    .valid_Out       (valid)
  );

  if_fetch_unit #(
    .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)
  ) dut2 (
    .clock_In        (clk),
    .reset_In        (rst),
    .stall_In        (stall2),
    .branch_taken_In (br2),
    .branch_target_In(tgt2),
    .imem_req_Out    (req2),
    .imem_addr_Out   (addr2),
    .imem_ack_In     (ack2),
    .imem_rdata_In   (rdata2),
    .instr_Out       (instr2),
    .pcOut_Out       (pco2),
    .valid_Out       (valid2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    br = 1'b0;
    tgt = '0;
    lat = 0;
    stall2 = 1'b0;
    br2 = 1'b0;
    tgt2 = '0;
    tick;
    tick;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_addr", addr, 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_pc", pco, 64'd0);

    rst = 1'b0;
    tick;
    chk("first_req", 64'(req), 64'd1);
    chk("first_addr", addr, 64'd0);
    chk("first_valid", 64'(valid), 64'd0);
    tick;
    chk("seq0_valid", 64'(valid), 64'd1);
    chk("seq0_pc", pco, 64'd0);
    chk("seq0_instr", 64'(instr), 64'hA5A5_0000);
    tick;
    chk("seq1_pc", pco, 64'd4);
    chk("seq1_instr", 64'(instr), 64'hA5A5_0004);
    chk("seq1_addr", addr, 64'd8);

    stall = 1'b1;
    tick;
    chk("stall1_req", 64'(req), 64'd0);
    chk("stall1_pc", pco, 64'd4);
    chk("stall1_valid", 64'(valid), 64'd1);
    tick;
    chk("stall2_req", 64'(req), 64'd0);
    tick;
    chk("stall3_req", 64'(req), 64'd0);
    chk("stall3_pc", pco, 64'd4);
    stall = 1'b0;
    tick;
    chk("skid_valid", 64'(valid), 64'd1);
    chk("skid_pc", pco, 64'd8);
    chk("skid_instr", 64'(instr), 64'hA5A5_0008);
    chk("skid_req", 64'(req), 64'd1);
    chk("skid_addr", addr, 64'd12);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    tick;
    tick;
    chk("pre_br_addr", addr, 64'd8);
    lat = 2;
    br = 1'b1;
    tgt = 64'h100;
    tick;
    br = 1'b0;
    chk("sq1_valid", 64'(valid), 64'd0);
    chk("sq1_req", 64'(req), 64'd1);
    chk("sq1_addr", addr, 64'd8);
    tick;
    chk("sq2_valid", 64'(valid), 64'd0);
    chk("sq2_addr", addr, 64'd8);
    tick;
    chk("sq3_valid", 64'(valid), 64'd0);
    chk("sq3_addr", addr, 64'h100);
    lat = 0;
    tick;
    chk("tgt_valid", 64'(valid), 64'd1);
    chk("tgt_pc", pco, 64'h100);
    chk("tgt_instr", 64'(instr), 64'hA5A5_0100);

    stall = 1'b1;
    tick;
    chk("full_req", 64'(req), 64'd0);
    chk("full_pc", pco, 64'h100);
    br = 1'b1;
    tgt = 64'h200;
    tick;
    br = 1'b0;
    stall = 1'b0;
    chk("wsbr_valid", 64'(valid), 64'd0);
    chk("wsbr_req", 64'(req), 64'd1);
    chk("wsbr_addr", addr, 64'h200);
    tick;
    chk("wsbr_out_valid", 64'(valid), 64'd1);
    chk("wsbr_out_pc", pco, 64'h200);

    br = 1'b1;
    tgt = 64'h300;
    tick;
    br = 1'b0;
    chk("ackbr_valid", 64'(valid), 64'd0);
    chk("ackbr_addr", addr, 64'h300);
    tick;
    chk("ackbr_out_valid", 64'(valid), 64'd1);
    chk("ackbr_out_pc", pco, 64'h300);

    lat = 5;
    tick;
    rst = 1'b1;
    tick;
    chk("mid_rst_req", 64'(req), 64'd0);
    chk("mid_rst_addr", addr, 64'd0);
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_instr", 64'(instr), 64'd0);
    chk("mid_rst_pc", pco, 64'd0);
    rst = 1'b0;
    lat = 0;
    tick;
    chk("post_rst_req", 64'(req), 64'd1);
    chk("post_rst_addr", addr, 64'd0);
    chk("wrap_req", 64'(req2), 64'd1);
    chk("wrap_addr0", addr2, 64'hFFFF_FFFF_FFFF_FFFC);
    tick;
    chk("post_rst_pc", pco, 64'd0);
    chk("post_rst_valid", 64'(valid), 64'd1);
    chk("wrap_valid", 64'(valid2), 64'd1);
    chk("wrap_pc", pco2, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr", 64'(instr2), 64'h5A5A_FFFC);
    chk("wrap_addr1", addr2, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
